// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment codes and scan helpers shared by the
// display driver and the scan-side decoder.
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_IDLE   = 4'hF;

   // Active-low {dp,g,f,e,d,c,b,a}, dp dark
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

   localparam logic [15:0][7:0] SEG_LUT = {
      SEG_F, SEG_E, SEG_D, SEG_C,
      SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4,
      SEG_3, SEG_2, SEG_1, SEG_0
   };

   typedef struct packed {
      logic [3:0][3:0] dig;
      logic [3:0]      dp;
   } frame_t;

   function automatic logic an_onehot(input logic [3:0] an);
      return (an == 4'hE) || (an == 4'hD) ||
             (an == 4'hB) || (an == 4'h7);
   endfunction

   function automatic logic [1:0] an_index(input logic [3:0] an);
      logic [1:0] idx;
      case (an)
         4'hD:    idx = 2'd1;
         4'hB:    idx = 2'd2;
         4'h7:    idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: inverse segment LUT, maps the seven segment
// lines (dp excluded) back to a hex nibble.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_LUT[i][6:0]) begin
            hit    = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a scanned active-low 4-digit bus
// and publishes the hex value once the frame is stable.
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE        = 4,
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT       = 1 << 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  AN,
   input  logic [7:0]  SEGMENT,
   output logic [15:0] value,
   output logic [3:0]  point,
   output logic        value_valid,
   output logic        update,
   output logic        err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    SAMPLE_AT = 8'(SETTLE - 1);
   localparam logic [3:0]    MATCH_MAX = 4'(STABLE_FRAMES);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

   logic [3:0]      an_q, an_d;
   logic [7:0]      seg_q, seg_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [3:0]      seen_q, seen_d;
   logic [3:0][3:0] dig_q, dig_d;
   logic [3:0]      dps_q, dps_d;
   frame_t          prev_q, prev_d;
   logic [3:0]      match_q, match_d;
   logic [TW-1:0]   to_q, to_d;
   logic [15:0]     value_q, value_d;
   logic [3:0]      point_q, point_d;
   logic            valid_q, valid_d;
   logic            update_q, update_d;
   logic            err_q, err_d;
   logic            done_q, done_d;

   logic       hit;
   logic [3:0] nibble;
   logic       at_pt;
   logic       sample;
   logic       discard;
   logic       complete;
   logic [1:0] idx;
   frame_t     cur;

   seg7_decode u_dec (
      .seg    (seg_q[6:0]),
      .hit    (hit),
      .nibble (nibble)
   );

   always_comb begin
      an_d     = AN;
      seg_d    = SEGMENT;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      dig_d    = dig_q;
      dps_d    = dps_q;
      prev_d   = prev_q;
      match_d  = match_q;
      to_d     = to_q;
      value_d  = value_q;
      point_d  = point_q;
      valid_d  = valid_q;
      update_d = 1'b0;
      err_d    = 1'b0;
      done_d   = done_q;
      complete = 1'b0;
      discard  = 1'b0;
      idx      = an_index(an_q);
      cur.dig  = dig_q;
      cur.dp   = dps_q;

      // Counter restarts on the same edge an_q takes a new code
      if (AN != an_q) begin
         cnt_d = '0;
      end else if (cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end

      at_pt  = (cnt_q == SAMPLE_AT);
      sample = at_pt && an_onehot(an_q);

      if (at_pt && !an_onehot(an_q) && an_q != AN_IDLE) begin
         discard = 1'b1;
      end
      if (sample && !hit) begin
         discard = 1'b1;
      end

      if (sample && hit) begin
         cur.dig[idx] = nibble;
         cur.dp[idx]  = ~seg_q[7];
         dig_d        = cur.dig;
         dps_d        = cur.dp;
         seen_d       = seen_q | (4'b0001 << idx);
         complete     = (seen_d == 4'hF);
      end

      if (discard) begin
         seen_d  = '0;
         match_d = '0;
         err_d   = 1'b1;
      end

      if (complete) begin
         seen_d = '0;
         prev_d = cur;
         to_d   = '0;
         if (cur != prev_q) begin
            match_d = 4'd1;
         end else if (match_q != MATCH_MAX) begin
            match_d = match_q + 4'd1;
         end
      end else if (to_q != TO_MAX) begin
         to_d = to_q + TW'(1);
      end

      if (to_d == TO_MAX) begin
         valid_d = 1'b0;
      end

      if (complete && match_d == MATCH_MAX) begin
         value_d  = cur.dig;
         point_d  = cur.dp;
         valid_d  = 1'b1;
         done_d   = 1'b1;
         update_d = !done_q || (cur.dig != value_q) ||
                    (cur.dp != point_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_q     <= AN_IDLE;
         seg_q    <= SEG_BLANK;
         cnt_q    <= '0;
         seen_q   <= '0;
         dig_q    <= '0;
         dps_q    <= '0;
         prev_q   <= '0;
         match_q  <= '0;
         to_q     <= '0;
         value_q  <= '0;
         point_q  <= '0;
         valid_q  <= 1'b0;
         update_q <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         an_q     <= an_d;
         seg_q    <= seg_d;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
         dig_q    <= dig_d;
         dps_q    <= dps_d;
         prev_q   <= prev_d;
         match_q  <= match_d;
         to_q     <= to_d;
         value_q  <= value_d;
         point_q  <= point_d;
         valid_q  <= valid_d;
         update_q <= update_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign value       = value_q;
   assign point       = point_q;
   assign value_valid = valid_q;
   assign update      = update_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized scan stimulus checked against
// a sample-level reference model of the decoder rules.
module tb_seg_scan_decoder;

   localparam int SETTLE = 4;
   localparam int STABLE = 2;
   localparam int TMO    = 300;
   localparam int HOLD   = 8;

   localparam logic [7:0] TB_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  AN;
   logic [7:0]  SEGMENT;
   logic [15:0] value;
   logic [3:0]  point;
   logic        value_valid;
   logic        update;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int upd_seen = 0;
   int err_seen = 0;

   // reference model state
   logic [3:0][3:0] m_dig;
   logic [3:0]      m_dp;
   logic [3:0]      m_seen;
   logic [19:0]     m_prev;
   int              m_match;
   logic [15:0]     m_value;
   logic [3:0]      m_point;
   logic            m_valid;
   logic            m_done;
   int              m_upd = 0;
   int              m_err = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .SETTLE        (SETTLE),
      .STABLE_FRAMES (STABLE),
      .TIMEOUT       (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .AN          (AN),
      .SEGMENT     (SEGMENT),
      .value       (value),
      .point       (point),
      .value_valid (value_valid),
      .update      (update),
      .err         (err)
   );

   always @(negedge clk) begin
      if (update === 1'b1) upd_seen++;
      if (err === 1'b1) err_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int lut_find(input logic [6:0] s);
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         e = TB_LUT[i];
         if (e[6:0] == s) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] enc(input logic [3:0] n,
                                      input logic dp);
      logic [7:0] c;
      c = TB_LUT[n];
      c[7] = ~dp;
      return c;
   endfunction

   task automatic m_reset();
      m_dig = '0; m_dp = '0; m_seen = '0; m_prev = '0;
      m_match = 0; m_value = '0; m_point = '0;
      m_valid = 1'b0; m_done = 1'b0;
   endtask

   task automatic m_discard();
      m_seen = '0;
      m_match = 0;
      m_err++;
   endtask

   task automatic m_sample(input int idx, input logic [7:0] code);
      int n;
      logic [19:0] fr;
      n = lut_find(code[6:0]);
      if (n < 0) begin
         m_discard();
      end else begin
         m_dig[idx]  = 4'(n);
         m_dp[idx]   = ~code[7];
         m_seen[idx] = 1'b1;
         if (m_seen == 4'hF) begin
            fr = {m_dig, m_dp};
            if (fr == m_prev)
               m_match = (m_match + 1 > STABLE) ? STABLE : m_match + 1;
            else
               m_match = 1;
            m_prev = fr;
            m_seen = '0;
            if (m_match == STABLE) begin
               if (!m_done || m_dig != m_value || m_dp != m_point)
                  m_upd++;
               m_value = m_dig;
               m_point = m_dp;
               m_valid = 1'b1;
               m_done  = 1'b1;
            end
         end
      end
   endtask

   task automatic drive(input logic [3:0] an, input logic [7:0] seg,
                        input int n);
      AN = an;
      SEGMENT = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_digit(input int idx, input logic [7:0] code,
                             input int n);
      drive(~(4'b0001 << idx), code, n);
      if (n >= SETTLE) m_sample(idx, code);
   endtask

   task automatic scan_frame(input logic [15:0] v, input logic [3:0] p,
                             input int n);
      for (int i = 0; i < 4; i++) scan_digit(i, enc(v[i*4 +: 4], p[i]), n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'hF, 8'hFF, 3);
      m_reset();
      checks += 5;
      if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h exp=0000", value); end
      if (point !== 4'h0) begin failures++; $display("FAIL reset_point got=%h exp=0", point); end
      if (value_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", value_valid); end
      if (update !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", update); end
      if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b0;
      drive(4'hF, 8'hFF, 2);
   endtask

   task automatic test_basic();
      scan_frame(16'h1234, 4'h0, HOLD);
      checks += 2;
      if (value_valid !== 1'b0) begin failures++; $display("FAIL basic_f1_valid got=%b exp=0", value_valid); end
      if (upd_seen !== 0) begin failures++; $display("FAIL basic_f1_upd got=%0d exp=0", upd_seen); end
      scan_frame(16'h1234, 4'h0, HOLD);
      checks += 4;
      if (value !== 16'h1234) begin failures++; $display("FAIL basic_value got=%h exp=1234", value); end
      if (value_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", value_valid); end
      if (upd_seen !== 1) begin failures++; $display("FAIL basic_upd got=%0d exp=1", upd_seen); end
      if (m_upd !== 1) begin failures++; $display("FAIL basic_model_upd got=%0d exp=1", m_upd); end
      scan_frame(16'h1234, 4'h0, HOLD);
      checks += 2;
      if (upd_seen !== m_upd) begin failures++; $display("FAIL basic_f3_upd got=%0d exp=%0d", upd_seen, m_upd); end
      if (value !== m_value) begin failures++; $display("FAIL basic_f3_value got=%h exp=%h", value, m_value); end
   endtask

   task automatic test_step();
      scan_frame(16'h0099, 4'h0, HOLD);
      scan_frame(16'h0099, 4'h0, HOLD);
      checks += 2;
      if (value !== 16'h0099) begin failures++; $display("FAIL step_0099 got=%h exp=0099", value); end
      if (upd_seen !== m_upd) begin failures++; $display("FAIL step_upd1 got=%0d exp=%0d", upd_seen, m_upd); end
      scan_frame(16'h0100, 4'h0, HOLD);
      scan_frame(16'h0100, 4'h0, HOLD);
      checks += 2;
      if (value !== 16'h0100) begin failures++; $display("FAIL step_0100 got=%h exp=0100", value); end
      if (upd_seen !== m_upd) begin failures++; $display("FAIL step_upd2 got=%0d exp=%0d", upd_seen, m_upd); end
   endtask

   task automatic test_bad_digit();
      int e0;
      e0 = err_seen;
      scan_digit(0, enc(4'hA, 1'b0), HOLD);
      scan_digit(1, enc(4'h5, 1'b0), HOLD);
      scan_digit(2, 8'hFF, HOLD);
      scan_digit(3, enc(4'h5, 1'b0), HOLD);
      checks += 3;
      if (err_seen !== e0 + 1) begin failures++; $display("FAIL bad_err got=%0d exp=%0d", err_seen, e0 + 1); end
      if (err_seen !== m_err) begin failures++; $display("FAIL bad_err_model got=%0d exp=%0d", err_seen, m_err); end
      if (value !== 16'h0100) begin failures++; $display("FAIL bad_nocommit got=%h exp=0100", value); end
      scan_frame(16'h5A5A, 4'h0, HOLD);
      scan_frame(16'h5A5A, 4'h0, HOLD);
      checks += 3;
      if (value !== m_value) begin failures++; $display("FAIL bad_recover got=%h exp=%h", value, m_value); end
      if (value !== 16'h5A5A) begin failures++; $display("FAIL bad_recover_const got=%h exp=5a5a", value); end
      if (upd_seen !== m_upd) begin failures++; $display("FAIL bad_upd got=%0d exp=%0d", upd_seen, m_upd); end
   endtask

   task automatic test_multihot_blank();
      int e0;
      e0 = err_seen;
      scan_digit(0, enc(4'h7, 1'b0), HOLD);
      scan_digit(1, enc(4'hE, 1'b0), HOLD);
      drive(4'b0011, enc(4'h3, 1'b0), HOLD);
      m_discard();
      scan_digit(2, enc(4'h3, 1'b0), HOLD);
      scan_digit(3, enc(4'hC, 1'b0), HOLD);
      checks += 2;
      if (err_seen !== e0 + 1) begin failures++; $display("FAIL multihot_err got=%0d exp=%0d", err_seen, e0 + 1); end
      if (value !== m_value) begin failures++; $display("FAIL multihot_value got=%h exp=%h", value, m_value); end
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 4; i++) begin
            scan_digit(i, enc(4'(16'hC3E7 >> (i * 4)), 1'b1), HOLD);
            drive(4'hF, 8'hFF, 3);
         end
      end
      checks += 4;
      if (err_seen !== m_err) begin failures++; $display("FAIL blank_err got=%0d exp=%0d", err_seen, m_err); end
      if (value !== m_value) begin failures++; $display("FAIL blank_value got=%h exp=%h", value, m_value); end
      if (point !== m_point) begin failures++; $display("FAIL blank_point got=%h exp=%h", point, m_point); end
      if (upd_seen !== m_upd) begin failures++; $display("FAIL blank_upd got=%0d exp=%0d", upd_seen, m_upd); end
   endtask

   task automatic test_random();
      logic [15:0] v;
      logic [3:0]  p;
      int rep;
      for (int g = 0; g < 12; g++) begin
         v = 16'($urandom);
         p = 4'($urandom);
         if (g % 3 == 2) p = 4'h0;
         rep = $urandom_range(1, 3);
         for (int r = 0; r < rep; r++) begin
            scan_frame(v, p, HOLD);
            checks += 5;
            if (value !== m_value) begin failures++; $display("FAIL rnd_value g=%0d got=%h exp=%h", g, value, m_value); end
            if (point !== m_point) begin failures++; $display("FAIL rnd_point g=%0d got=%h exp=%h", g, point, m_point); end
            if (value_valid !== m_valid) begin failures++; $display("FAIL rnd_valid g=%0d got=%b exp=%b", g, value_valid, m_valid); end
            if (upd_seen !== m_upd) begin failures++; $display("FAIL rnd_upd g=%0d got=%0d exp=%0d", g, upd_seen, m_upd); end
            if (err_seen !== m_err) begin failures++; $display("FAIL rnd_err g=%0d got=%0d exp=%0d", g, err_seen, m_err); end
         end
      end
   endtask

   task automatic test_timeout();
      drive(4'hF, 8'hFF, TMO - 60);
      checks += 1;
      if (value_valid !== 1'b1) begin failures++; $display("FAIL tmo_early got=%b exp=1", value_valid); end
      drive(4'hF, 8'hFF, 120);
      m_valid = 1'b0;
      checks += 2;
      if (value_valid !== m_valid) begin failures++; $display("FAIL tmo_valid got=%b exp=0", value_valid); end
      if (value !== m_value) begin failures++; $display("FAIL tmo_hold got=%h exp=%h", value, m_value); end
   endtask

   task automatic test_short_hold();
      int u0, e0;
      u0 = upd_seen;
      e0 = err_seen;
      for (int f = 0; f < 3; f++) scan_frame(16'h4321, 4'h0, SETTLE - 1);
      drive(4'hF, 8'hFF, 4);
      checks += 4;
      if (value_valid !== 1'b0) begin failures++; $display("FAIL short_valid got=%b exp=0", value_valid); end
      if (upd_seen !== u0) begin failures++; $display("FAIL short_upd got=%0d exp=%0d", upd_seen, u0); end
      if (err_seen !== e0) begin failures++; $display("FAIL short_err got=%0d exp=%0d", err_seen, e0); end
      if (value !== m_value) begin failures++; $display("FAIL short_value got=%h exp=%h", value, m_value); end
   endtask

   task automatic test_reset_mid();
      scan_frame(16'h7777, 4'h0, HOLD);
      scan_frame(16'h7777, 4'h0, HOLD);
      scan_digit(0, enc(4'h7, 1'b0), HOLD);
      scan_digit(1, enc(4'h7, 1'b0), HOLD);
      checks += 1;
      if (value_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", value_valid); end
      rst = 1'b1;
      drive(4'hF, 8'hFF, 1);
      m_reset();
      checks += 5;
      if (value !== 16'h0000) begin failures++; $display("FAIL rstmid_value got=%h exp=0000", value); end
      if (point !== 4'h0) begin failures++; $display("FAIL rstmid_point got=%h exp=0", point); end
      if (value_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", value_valid); end
      if (update !== 1'b0) begin failures++; $display("FAIL rstmid_update got=%b exp=0", update); end
      if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err); end
      rst = 1'b0;
      drive(4'hF, 8'hFF, 2);
      scan_frame(16'h0000, 4'h0, HOLD);
      checks += 1;
      if (value_valid !== 1'b0) begin failures++; $display("FAIL rstmid_f1_valid got=%b exp=0", value_valid); end
      scan_frame(16'h0000, 4'h0, HOLD);
      checks += 3;
      if (value_valid !== m_valid) begin failures++; $display("FAIL rstmid_f2_valid got=%b exp=%b", value_valid, m_valid); end
      if (value !== m_value) begin failures++; $display("FAIL rstmid_f2_value got=%h exp=%h", value, m_value); end
      if (upd_seen !== m_upd) begin failures++; $display("FAIL rstmid_first_upd got=%0d exp=%0d", upd_seen, m_upd); end
   endtask

   initial begin
      rst = 1'b1;
      AN = 4'hF;
      SEGMENT = 8'hFF;
      m_reset();
      test_reset();
      test_basic();
      test_step();
      test_bad_digit();
      test_multihot_blank();
      test_random();
      test_timeout();
      test_short_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
